// File: rtl/ecap5_dwbuart_wbm_if.sv
// Request/response and Wishbone signal bundle for the
// ecap5_dwbuart single-outstanding bus initiator.
interface ecap5_dwbuart_wbm_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stall_i;

  modport master (
    input  req_valid_i,
    output req_ready_o,
    input  req_addr_i,
    input  req_we_i,
    input  req_sel_i,
    input  req_wdata_i,
    output rsp_valid_o,
    output rsp_rdata_o,
    output rsp_err_o,
    output wb_adr_o,
    output wb_dat_o,
    input  wb_dat_i,
    output wb_we_o,
    output wb_sel_o,
    output wb_stb_o,
    input  wb_ack_i,
    output wb_cyc_o,
    input  wb_stall_i
  );

  modport slave (
    output req_valid_i,
    input  req_ready_o,
    output req_addr_i,
    output req_we_i,
    output req_sel_i,
    output req_wdata_i,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  rsp_err_o,
    input  wb_adr_o,
    input  wb_dat_o,
    output wb_dat_i,
    input  wb_we_o,
    input  wb_sel_o,
    input  wb_stb_o,
    output wb_ack_i,
    input  wb_cyc_o,
    output wb_stall_i
  );
endinterface

// File: rtl/ecap5_dwbuart_wbm.sv
// Single-outstanding Wishbone B4 pipelined initiator.
// One valid/ready request becomes one wb cycle with timeout.
module ecap5_dwbuart_wbm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input logic clk_i,
  input logic rst_i,
  ecap5_dwbuart_wbm_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT_ACK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // State, latched request and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state: accept, strobe, wait for ack or expire
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req_valid_i) begin
          adr_d   = bus.req_addr_i;
          dat_d   = bus.req_wdata_i;
          we_d    = bus.req_we_i;
          sel_d   = bus.req_sel_i;
          state_d = REQUEST;
        end
      end
      REQUEST, WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.wb_ack_i) begin
          // ack beats expiry when both land together
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : bus.wb_dat_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (state_q == REQUEST &&
                     !bus.wb_stall_i) begin
          state_d = WAIT_ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.wb_cyc_o    = (state_q != IDLE);
  assign bus.wb_stb_o    = (state_q == REQUEST);
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
